ctrl_pipeline: RTL and testbench
================================

# ctrl_pipeline

Pipelined control-path and hazard unit for the 5-stage RISC-V core. It consumes the per-instruction control bundle produced by the main decoder in ID and carries it through the ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and stalls the front end, and squashes wrong-path instructions on a taken branch or jump. It also produces the EX-stage operand forwarding selects for the datapath.

## Interface
- `REG_W`, default 5: register-index width.
- `ALUOP_W`, default 2: ALUop width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all stage registers.
- `id_valid`  in  1  ID holds a real, decodable instruction. When 0, the ID control bits are ignored and a bubble is used.
- `id_alusrc`, `id_memtoreg`, `id_regwrite`, `id_memread`, `id_memwrite`, `id_branch`, `id_jump`  in  1 each  decoder control bits.
- `id_aluop`  in  ALUOP_W  decoder ALUop.
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_W  ID register indices.
- `ex_cond`  in  1  branch comparison result from the EX datapath.
- `pc_write`  out  1  PC may update.
- `ifid_write`  out  1  IF/ID may load.
- `ifid_flush`  out  1  IF/ID loads a NOP on the next edge.
- `redirect`  out  1  PC takes the EX target.
- `ex_valid`, `ex_alusrc`, `ex_branch`, `ex_jump`, `ex_memread`, `ex_memwrite`, `ex_regwrite`, `ex_memtoreg`  out  1 each  ID/EX register.
- `ex_aluop`  out  ALUOP_W  ID/EX register.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  REG_W  ID/EX register.
- `mem_valid`, `mem_memread`, `mem_memwrite`, `mem_regwrite`, `mem_memtoreg`  out  1 each  EX/MEM register.
- `mem_rd`  out  REG_W  EX/MEM register.
- `wb_valid`, `wb_regwrite`, `wb_memtoreg`  out  1 each  MEM/WB register.
- `wb_rd`  out  REG_W  MEM/WB register.
- `fwd_a`, `fwd_b`  out  2  EX operand select: 00 = register file, 10 = MEM-stage result, 01 = WB-stage result.

## Operation
- **Bubble:** every control bit is 0, `valid` is 0, and every rd/rs index is 0.
- **Gated writes:** a stage's regwrite, memread and memwrite are only asserted when that stage's `valid` is 1.
- **load_use** = `ex_valid & ex_memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & id_valid`.
- **redirect** = `ex_valid & (ex_jump | (ex_branch & ex_cond))`.
- **Priority:** redirect over load_use. When both are true, treat the cycle as a redirect only (`pc_write` = 1, no stall).
- **Normal advance:** ID/EX ← ID bundle, or a bubble if `id_valid` = 0. EX/MEM ← ID/EX. MEM/WB ← EX/MEM.
- **Load-use stall:**
  - `pc_write` = 0 and `ifid_write` = 0.
  - ID/EX ← bubble.
  - EX/MEM and MEM/WB advance normally.
  - Exactly one stall cycle per hazard. The load is in MEM on the next cycle, so the condition clears.
- **Redirect:**
  - `ifid_flush` = 1, `pc_write` = 1, `ifid_write` = 1.
  - ID/EX ← bubble.
  - The branch/jump itself advances to MEM.
- **Forwarding for fwd_a (rs = ex_rs1); fwd_b is identical using ex_rs2:**
  - 10 if `mem_valid & mem_regwrite & (mem_rd != 0) & (mem_rd == rs)`.
  - Otherwise 01 if `wb_valid & wb_regwrite & (wb_rd != 0) & (wb_rd == rs)`.
  - Otherwise 00.
  - MEM has priority over WB.
- **x0:** never a hazard or forwarding source.
- **Combinational outputs:** `pc_write`, `ifid_write`, `ifid_flush`, `redirect`, `fwd_a` and `fwd_b` are combinational from the current register state and ID inputs. No path from an output feeds back to an input.

## Timing
- **Stage outputs:** all stage-register outputs change only on the `clk` rising edge or asynchronously on `reset`.
- **Reset values:**
  - All ex_/mem_/wb_ outputs = 0.
  - `fwd_a` = `fwd_b` = 00.
  - `redirect` = 0, `ifid_flush` = 0.
  - `pc_write` = 1, `ifid_write` = 1 (pipeline empty, no hazard).
- **Reset mid-operation:** all in-flight instructions are discarded immediately. The first edge after deassertion loads ID normally.
- **Latency:** an ID bundle appears on ex_ one edge later, mem_ two edges later, wb_ three edges later (absent stall or flush).
- **Load-use penalty:** 1 bubble.
- **Taken branch/jump penalty:** 2 bubbles (the IF/ID NOP plus the ID/EX bubble).
- **Repeated stall:** a stalled ID instruction is re-evaluated each cycle. Only a second load in EX could re-stall it, and the bubble guarantees that cannot happen.

## Test plan
- **Reset mid-run:** assert `reset` with all three stages valid → all stage outputs are 0 within the same cycle. `pc_write` = 1, `fwd_a` = `fwd_b` = 00.
- **Back-to-back ALU dependency:** `add x5,x1,x2` then `add x7,x5,x3` → with the second instruction in EX, `fwd_a` = 10 and `fwd_b` = 00. One cycle later, a third instruction using rs2 = x5 sees `fwd_b` = 01.
- **Load-use:** `lw x6` then `add` with rs1 = x6 → exactly one cycle of `pc_write` = `ifid_write` = 0, `ex_valid` = 0 on the next edge. Then the add in EX sees `fwd_a` = 01.
- **Taken beq:** beq in EX with `ex_cond` = 1 → `redirect` = `ifid_flush` = 1 for one cycle. The next two cycles show `ex_valid` = 0, and `mem_valid` = 1 carries the branch. With `ex_cond` = 0, no flush occurs.
- **x0 and priority:**
  - `lw x0` followed by a use of x0 → no stall, `fwd_a` = 00.
  - `mem_rd` = `wb_rd` = x9, both writing, and `ex_rs1` = x9 → `fwd_a` = 10.
- **Simultaneous redirect and load_use:** a jal in EX forced alongside a forced load-use ID condition → `redirect` = 1, `pc_write` = 1, `ifid_write` = 1, and no stall cycle occurs.

Source files
------------

// File: rtl/ctrl_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipeline_if
// Brief    : ID control bundle in, stage registers / hazard controls out.
// Revision : 1.0 - initial release
// ============================================================================
interface ctrl_pipeline_if #(
   parameter int REG_W   = 5,
   parameter int ALUOP_W = 2
);
   logic               id_valid;
   logic               id_alusrc, id_memtoreg, id_regwrite, id_memread;
   logic               id_memwrite, id_branch, id_jump;
   logic [ALUOP_W-1:0] id_aluop;
   logic [REG_W-1:0]   id_rs1, id_rs2, id_rd;
   logic               ex_cond;

   logic               pc_write, ifid_write, ifid_flush, redirect;
   logic               ex_valid, ex_alusrc, ex_branch, ex_jump;
   logic               ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
   logic [ALUOP_W-1:0] ex_aluop;
   logic [REG_W-1:0]   ex_rs1, ex_rs2, ex_rd;
   logic               mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
   logic [REG_W-1:0]   mem_rd;
   logic               wb_valid, wb_regwrite, wb_memtoreg;
   logic [REG_W-1:0]   wb_rd;
   logic [1:0]         fwd_a, fwd_b;

   modport master (
      output id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread,
             id_memwrite, id_branch, id_jump, id_aluop, id_rs1, id_rs2, id_rd, ex_cond,
      input  pc_write, ifid_write, ifid_flush, redirect,
             ex_valid, ex_alusrc, ex_branch, ex_jump, ex_memread, ex_memwrite,
             ex_regwrite, ex_memtoreg, ex_aluop, ex_rs1, ex_rs2, ex_rd,
             mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_rd,
             wb_valid, wb_regwrite, wb_memtoreg, wb_rd, fwd_a, fwd_b
   );

   modport slave (
      input  id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread,
             id_memwrite, id_branch, id_jump, id_aluop, id_rs1, id_rs2, id_rd, ex_cond,
      output pc_write, ifid_write, ifid_flush, redirect,
             ex_valid, ex_alusrc, ex_branch, ex_jump, ex_memread, ex_memwrite,
             ex_regwrite, ex_memtoreg, ex_aluop, ex_rs1, ex_rs2, ex_rd,
             mem_valid, mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_rd,
             wb_valid, wb_regwrite, wb_memtoreg, wb_rd, fwd_a, fwd_b
   );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipeline
// Brief    : ID/EX, EX/MEM, MEM/WB control registers, load-use stall,
//            branch/jump squash and EX operand forwarding selects.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipeline #(
   parameter int REG_W   = 5,
   parameter int ALUOP_W = 2
) (
   input  wire logic         clk,
   input  wire logic         reset,
   ctrl_pipeline_if.slave    bus
);
   localparam logic [REG_W-1:0] c_x0       = '0;
   localparam logic [1:0]       c_fwd_rf   = 2'b00;
   localparam logic [1:0]       c_fwd_mem  = 2'b10;
   localparam logic [1:0]       c_fwd_wb   = 2'b01;

   logic               r_ex_valid, r_ex_alusrc, r_ex_branch, r_ex_jump;
   logic               r_ex_memread, r_ex_memwrite, r_ex_regwrite, r_ex_memtoreg;
   logic [ALUOP_W-1:0] r_ex_aluop;
   logic [REG_W-1:0]   r_ex_rs1, r_ex_rs2, r_ex_rd;
   logic               r_mem_valid, r_mem_memread, r_mem_memwrite, r_mem_regwrite, r_mem_memtoreg;
   logic [REG_W-1:0]   r_mem_rd;
   logic               r_wb_valid, r_wb_regwrite, r_wb_memtoreg;
   logic [REG_W-1:0]   r_wb_rd;

   logic w_load_use, w_redirect, w_stall, w_take_id;

   assign w_load_use = r_ex_valid & r_ex_memread & (r_ex_rd != c_x0) &
                       ((r_ex_rd == bus.id_rs1) | (r_ex_rd == bus.id_rs2)) & bus.id_valid;
   assign w_redirect = r_ex_valid & (r_ex_jump | (r_ex_branch & bus.ex_cond));
   // A redirect squashes the stalled ID instruction anyway, so it wins.
   assign w_stall    = w_load_use & ~w_redirect;
   assign w_take_id  = bus.id_valid & ~w_stall & ~w_redirect;

   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
      if (r_mem_valid & r_mem_regwrite & (r_mem_rd != c_x0) & (r_mem_rd == rs))
         return c_fwd_mem;
      else if (r_wb_valid & r_wb_regwrite & (r_wb_rd != c_x0) & (r_wb_rd == rs))
         return c_fwd_wb;
      else
         return c_fwd_rf;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex_valid     <= 1'b0;
         r_ex_alusrc    <= 1'b0;
         r_ex_branch    <= 1'b0;
         r_ex_jump      <= 1'b0;
         r_ex_memread   <= 1'b0;
         r_ex_memwrite  <= 1'b0;
         r_ex_regwrite  <= 1'b0;
         r_ex_memtoreg  <= 1'b0;
         r_ex_aluop     <= '0;
         r_ex_rs1       <= '0;
         r_ex_rs2       <= '0;
         r_ex_rd        <= '0;
         r_mem_valid    <= 1'b0;
         r_mem_memread  <= 1'b0;
         r_mem_memwrite <= 1'b0;
         r_mem_regwrite <= 1'b0;
         r_mem_memtoreg <= 1'b0;
         r_mem_rd       <= '0;
         r_wb_valid     <= 1'b0;
         r_wb_regwrite  <= 1'b0;
         r_wb_memtoreg  <= 1'b0;
         r_wb_rd        <= '0;
      end else begin
         if (w_take_id) begin
            r_ex_valid    <= 1'b1;
            r_ex_alusrc   <= bus.id_alusrc;
            r_ex_branch   <= bus.id_branch;
            r_ex_jump     <= bus.id_jump;
            r_ex_memread  <= bus.id_memread;
            r_ex_memwrite <= bus.id_memwrite;
            r_ex_regwrite <= bus.id_regwrite;
            r_ex_memtoreg <= bus.id_memtoreg;
            r_ex_aluop    <= bus.id_aluop;
            r_ex_rs1      <= bus.id_rs1;
            r_ex_rs2      <= bus.id_rs2;
            r_ex_rd       <= bus.id_rd;
         end else begin
            r_ex_valid    <= 1'b0;
            r_ex_alusrc   <= 1'b0;
            r_ex_branch   <= 1'b0;
            r_ex_jump     <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memtoreg <= 1'b0;
            r_ex_aluop    <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
         end
         // Later stages never stall; writes stay gated by valid.
         r_mem_valid    <= r_ex_valid;
         r_mem_memread  <= r_ex_valid & r_ex_memread;
         r_mem_memwrite <= r_ex_valid & r_ex_memwrite;
         r_mem_regwrite <= r_ex_valid & r_ex_regwrite;
         r_mem_memtoreg <= r_ex_valid & r_ex_memtoreg;
         r_mem_rd       <= r_ex_valid ? r_ex_rd : c_x0;
         r_wb_valid     <= r_mem_valid;
         r_wb_regwrite  <= r_mem_valid & r_mem_regwrite;
         r_wb_memtoreg  <= r_mem_valid & r_mem_memtoreg;
         r_wb_rd        <= r_mem_valid ? r_mem_rd : c_x0;
      end
   end

   assign bus.pc_write     = ~w_stall;
   assign bus.ifid_write   = ~w_stall;
   assign bus.ifid_flush   = w_redirect;
   assign bus.redirect     = w_redirect;
   assign bus.fwd_a        = fwd_sel(r_ex_rs1);
   assign bus.fwd_b        = fwd_sel(r_ex_rs2);

   assign bus.ex_valid     = r_ex_valid;
   assign bus.ex_alusrc    = r_ex_alusrc;
   assign bus.ex_branch    = r_ex_branch;
   assign bus.ex_jump      = r_ex_jump;
   assign bus.ex_memread   = r_ex_memread;
   assign bus.ex_memwrite  = r_ex_memwrite;
   assign bus.ex_regwrite  = r_ex_regwrite;
   assign bus.ex_memtoreg  = r_ex_memtoreg;
   assign bus.ex_aluop     = r_ex_aluop;
   assign bus.ex_rs1       = r_ex_rs1;
   assign bus.ex_rs2       = r_ex_rs2;
   assign bus.ex_rd        = r_ex_rd;
   assign bus.mem_valid    = r_mem_valid;
   assign bus.mem_memread  = r_mem_memread;
   assign bus.mem_memwrite = r_mem_memwrite;
   assign bus.mem_regwrite = r_mem_regwrite;
   assign bus.mem_memtoreg = r_mem_memtoreg;
   assign bus.mem_rd       = r_mem_rd;
   assign bus.wb_valid     = r_wb_valid;
   assign bus.wb_regwrite  = r_wb_regwrite;
   assign bus.wb_memtoreg  = r_wb_memtoreg;
   assign bus.wb_rd        = r_wb_rd;
endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipeline
// Brief    : Directed self-checking bench for ctrl_pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipeline;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   ctrl_pipeline_if #(.REG_W(5), .ALUOP_W(2)) bus ();
   ctrl_pipeline #(.REG_W(5), .ALUOP_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic alusrc, input logic memtoreg,
                        input logic regwrite, input logic memread, input logic memwrite,
                        input logic branch, input logic jump, input logic [1:0] aluop,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      bus.id_valid    = v;
      bus.id_alusrc   = alusrc;
      bus.id_memtoreg = memtoreg;
      bus.id_regwrite = regwrite;
      bus.id_memread  = memread;
      bus.id_memwrite = memwrite;
      bus.id_branch   = branch;
      bus.id_jump     = jump;
      bus.id_aluop    = aluop;
      bus.id_rs1      = rs1;
      bus.id_rs2      = rs2;
      bus.id_rd       = rd;
   endtask

   task automatic id_nop();                                   drive(0,0,0,0,0,0,0,0,2'd0,5'd0,5'd0,5'd0); endtask
   task automatic id_alu(input logic [4:0] rd, rs1, rs2);     drive(1,0,0,1,0,0,0,0,2'd2,rs1,rs2,rd);     endtask
   task automatic id_load(input logic [4:0] rd, rs1);         drive(1,1,1,1,1,0,0,0,2'd0,rs1,5'd0,rd);    endtask
   task automatic id_beq(input logic [4:0] rs1, rs2);         drive(1,0,0,0,0,0,1,0,2'd1,rs1,rs2,5'd0);   endtask

   task automatic drain();
      id_nop();
      repeat (3) step();
   endtask

   initial begin
      bus.ex_cond = 1'b0;
      id_nop();
      step();
      check("rst_ex_valid",   bus.ex_valid,   0);
      check("rst_mem_valid",  bus.mem_valid,  0);
      check("rst_wb_valid",   bus.wb_valid,   0);
      check("rst_pc_write",   bus.pc_write,   1);
      check("rst_ifid_write", bus.ifid_write, 1);
      check("rst_flush",      bus.ifid_flush, 0);
      check("rst_redirect",   bus.redirect,   0);
      check("rst_fwd",        {bus.fwd_a, bus.fwd_b}, 4'b0000);
      reset = 1'b0;

      // back-to-back ALU dependency
      id_alu(5'd5, 5'd1, 5'd2);  step();
      id_alu(5'd7, 5'd5, 5'd3);  step();
      check("alu_fwd_a_mem", bus.fwd_a, 2'b10);
      check("alu_fwd_b_rf",  bus.fwd_b, 2'b00);
      id_alu(5'd8, 5'd4, 5'd5);  step();
      check("alu_fwd_b_wb",  bus.fwd_b, 2'b01);
      check("alu_fwd_a_rf",  bus.fwd_a, 2'b00);
      check("lat_wb",        {bus.wb_valid, bus.wb_regwrite, bus.wb_rd}, {2'b11, 5'd5});
      check("lat_mem",       {bus.mem_valid, bus.mem_rd}, {1'b1, 5'd7});
      check("lat_ex",        {bus.ex_valid, bus.ex_aluop, bus.ex_rd}, {1'b1, 2'd2, 5'd8});
      drain();

      // load-use
      id_load(5'd6, 5'd1);       step();
      check("lw_ex_memread", bus.ex_memread, 1);
      id_alu(5'd9, 5'd6, 5'd2);
      #1;
      check("lu_pc_write",   bus.pc_write,   0);
      check("lu_ifid_write", bus.ifid_write, 0);
      step();
      check("lu_bubble",     bus.ex_valid,   0);
      check("lu_mem_lw",     {bus.mem_valid, bus.mem_memread, bus.mem_rd}, {2'b11, 5'd6});
      check("lu_release",    {bus.pc_write, bus.ifid_write}, 2'b11);
      step();
      check("lu_add_in_ex",  {bus.ex_valid, bus.ex_rd}, {1'b1, 5'd9});
      check("lu_fwd_a_wb",   bus.fwd_a, 2'b01);
      drain();

      // taken beq
      id_beq(5'd1, 5'd2);        step();
      id_alu(5'd10, 5'd1, 5'd2);
      bus.ex_cond = 1'b1;
      #1;
      check("br_redirect",   {bus.redirect, bus.ifid_flush, bus.pc_write, bus.ifid_write}, 4'b1111);
      step();
      bus.ex_cond = 1'b0;
      id_nop();
      check("br_sq1_ex",     bus.ex_valid, 0);
      check("br_sq1_mem",    {bus.mem_valid, bus.mem_regwrite, bus.mem_memwrite}, 3'b100);
      check("br_one_cycle",  {bus.redirect, bus.ifid_flush}, 2'b00);
      step();
      check("br_sq2_ex",     bus.ex_valid, 0);
      check("br_sq2_wb",     bus.wb_valid, 1);
      // not taken
      id_beq(5'd3, 5'd4);        step();
      id_alu(5'd11, 5'd1, 5'd2);
      #1;
      check("nt_no_redirect", {bus.redirect, bus.ifid_flush, bus.pc_write}, 3'b001);
      step();
      check("nt_next_in_ex", {bus.ex_valid, bus.ex_rd}, {1'b1, 5'd11});
      drain();

      // x0 never a hazard or forwarding source
      id_load(5'd0, 5'd1);       step();
      id_alu(5'd12, 5'd0, 5'd0);
      #1;
      check("x0_no_stall",   {bus.pc_write, bus.ifid_write}, 2'b11);
      step();
      check("x0_in_ex",      bus.ex_valid, 1);
      check("x0_fwd",        {bus.fwd_a, bus.fwd_b}, 4'b0000);
      drain();

      // MEM over WB priority
      id_alu(5'd9, 5'd1, 5'd2);  step();
      id_alu(5'd9, 5'd3, 5'd4);  step();
      id_alu(5'd13, 5'd9, 5'd9); step();
      check("prio_fwd_a",    bus.fwd_a, 2'b10);
      check("prio_fwd_b",    bus.fwd_b, 2'b10);
      drain();

      // jal carrying memread forced into EX alongside a load-use condition
      drive(1,0,0,1,1,0,0,1,2'd0,5'd0,5'd0,5'd14); step();
      id_alu(5'd15, 5'd14, 5'd1);
      #1;
      check("both_outputs",  {bus.redirect, bus.ifid_flush, bus.pc_write, bus.ifid_write}, 4'b1111);
      step();
      check("both_bubble",   bus.ex_valid, 0);
      check("both_mem_jal",  {bus.mem_valid, bus.mem_rd}, {1'b1, 5'd14});
      id_alu(5'd16, 5'd1, 5'd2); step();
      check("both_no_stall", {bus.ex_valid, bus.ex_rd}, {1'b1, 5'd16});
      drain();

      // reset mid-run with all stages valid
      id_alu(5'd20, 5'd1, 5'd2);  step();
      id_alu(5'd21, 5'd20, 5'd20); step();
      id_alu(5'd22, 5'd21, 5'd20); step();
      check("pre_rst_fwd",   {bus.fwd_a, bus.fwd_b}, 4'b1001);
      check("pre_rst_valid", {bus.ex_valid, bus.mem_valid, bus.wb_valid}, 3'b111);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", {bus.ex_valid, bus.mem_valid, bus.wb_valid}, 3'b000);
      check("mid_rst_rw",    {bus.mem_regwrite, bus.wb_regwrite, bus.ex_rd, bus.wb_rd}, 12'd0);
      check("mid_rst_pc",    {bus.pc_write, bus.ifid_write}, 2'b11);
      check("mid_rst_fwd",   {bus.fwd_a, bus.fwd_b}, 4'b0000);
      step();
      reset = 1'b0;
      id_alu(5'd17, 5'd1, 5'd2);
      step();
      check("post_rst_load", {bus.ex_valid, bus.ex_rd, bus.mem_valid}, {1'b1, 5'd17, 1'b0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
